rgals_tx_credit_queue: RTL

//  Left-domain sender feeding the RGALS suppressor's from_left input.

---
 rtl/rgals_pkg.sv | 15 +
 rtl/rgals_fifo.sv | 58 +++++
 rtl/rgals_tx_credit_queue.sv | 116 +++++++++++
 3 files changed

// File: rtl/rgals_pkg.sv
// rgals_pkg: types and constants shared by the RGALS suppressor, the TX credit queue and the RX block.
// The link word is {val, payload}; the valid flag sits directly above the payload.
package rgals_pkg;

    localparam int RGALS_DATA_WIDTH   = 8;
    localparam int RGALS_LINK_VAL_BIT = RGALS_DATA_WIDTH;

    typedef logic [RGALS_DATA_WIDTH-1:0] rgals_msg_t;

    // Bits needed to hold every credit value 0..credits.
    function automatic int rgals_credit_width(input int credits);
        return (credits < 1) ? 1 : $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/rgals_fifo.sv
// rgals_fifo: p_depth x p_data_width register-file FIFO with head/tail pointers and an occupancy count.
// Head data is readable combinationally; a push and a pop in the same cycle are legal even when full.
module rgals_fifo #(
    parameter int p_depth      = 4,
    parameter int p_data_width = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [p_data_width-1:0] push_data,
    input  logic                    pop,
    output logic [p_data_width-1:0] head,
    output logic                    full,
    output logic                    empty
);

    localparam int ptr_w = $clog2(p_depth);
    localparam logic [ptr_w:0] depth_c = (ptr_w + 1)'(p_depth);

    logic [p_data_width-1:0] mem [p_depth];
    logic [ptr_w-1:0]        rd_ptr;
    logic [ptr_w-1:0]        wr_ptr;
    logic [ptr_w:0]          count;

    // NOTE: the storage array has no reset; count alone decides which entries are valid,
    // so the array stays plain enable flops with no reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are log2(depth) bits and wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == depth_c);
    assign empty = (count == '0);

endmodule

// File: rtl/rgals_tx_credit_queue.sv
// rgals_tx_credit_queue: left-domain RGALS sender; buffers messages and launches one per transfer window when a credit is held.
// Optional: define RGALS_TX_PERF_EN to add the stall_cnt performance counter.
module rgals_tx_credit_queue
    import rgals_pkg::*;
#(
    parameter int p_period     = 5,
    parameter int p_data_width = $bits(rgals_msg_t),
    parameter int p_depth      = 4,
    parameter int p_credits    = 2
) (
    input  logic                    clk_left,
    input  logic                    clk_reset_n,
    input  logic                    enq_val,
    output logic                    enq_rdy,
    input  logic [p_data_width-1:0] enq_msg,
    output logic [p_data_width:0]   link_out,
    input  logic                    link_in,
    output logic                    credit_err
`ifdef RGALS_TX_PERF_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    localparam int phase_w  = (p_period > 1) ? $clog2(p_period) : 1;
    localparam int credit_w = rgals_credit_width(p_credits);
    localparam int val_bit  = p_data_width + RGALS_LINK_VAL_BIT - RGALS_DATA_WIDTH;

    localparam logic [phase_w-1:0]  phase_last = phase_w'(p_period - 1);
    localparam logic [credit_w-1:0] credit_max = credit_w'(p_credits);

    logic [phase_w-1:0]      phase;
    logic [credit_w-1:0]     credits;
    logic [p_data_width-1:0] head;
    logic                    full;
    logic                    empty;
    logic                    window;
    logic                    send;
    logic                    ret;
    logic                    fire;

    // Phase must track the suppressor's left counter exactly; both leave reset on the same edge.
    always_ff @(posedge clk_left or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            phase <= '0;
        end else if (phase == phase_last) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign window  = (phase == '0);
    assign enq_rdy = ~full;
    assign fire    = enq_val & ~full;
    assign send    = window & ~empty & (credits != '0);
    assign ret     = window & link_in;

    rgals_fifo #(
        .p_depth      (p_depth),
        .p_data_width (p_data_width)
    ) u_fifo (
        .clk       (clk_left),
        .rst_n     (clk_reset_n),
        .push      (fire),
        .push_data (enq_msg),
        .pop       (send),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // send depends only on registered state, so link_out never sees enq_* combinationally
    // and drops to zero the moment reset empties the FIFO.
    always_comb begin
        // NOTE: default first so every path assigns link_out and no latch is inferred.
        link_out = '0;
        if (send) begin
            link_out[val_bit]          = 1'b1;
            link_out[p_data_width-1:0] = head;
        end
    end

    // A return while all credits are home means the receiver returned one it never had.
    always_ff @(posedge clk_left or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            credits    <= credit_max;
            credit_err <= 1'b0;
        end else begin
            if (ret && (credits == credit_max)) begin
                credit_err <= 1'b1;
            end
            case ({send, ret})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    if (credits != credit_max) begin
                        credits <= credits + 1'b1;
                    end
                end
                default: credits <= credits;
            endcase
        end
    end

`ifdef RGALS_TX_PERF_EN
    // Counts windows lost to credit starvation while data is waiting.
    always_ff @(posedge clk_left or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            stall_cnt <= '0;
        end else if (window && !empty && (credits == '0)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
